apb_master_ctrl: RTL and testbench

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

---
 rtl/apb_pkg.sv | 7 +
 rtl/apb_master_ctrl_if.sv | 44 ++++
 rtl/apb_timeout_counter.sv | 21 ++
 rtl/apb_master_ctrl.sv | 86 ++++++++
 tb/tb_apb_master_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared controller state encoding and APB response codes
package apb_pkg;
    typedef enum logic [1:0] {IDLE, ADDRESS, DATA, RESP} state_t;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;
endpackage

// File: rtl/apb_master_ctrl_if.sv
// apb_master_ctrl_if: request/response handshake plus APB completer bus
interface apb_master_ctrl_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    logic                         req_valid;
    logic                         req_ready;
    logic [ADDR_W-1:0]            req_addr;
    logic                         req_write;
    logic [DATA_W-1:0]            req_wdata;
    logic [DATA_W/8-1:0]          req_strb;
    logic [2:0]                   req_prot;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [DATA_W-1:0]            rsp_rdata;
    logic [1:0]                   rsp_resp;
    logic                         rsp_timeout;
    logic                         p_clk_en;
    logic [NUM_SLAVES-1:0]        p_sel;
    logic                         p_enable;
    logic [ADDR_W-1:0]            p_addr;
    logic                         p_write;
    logic [DATA_W-1:0]            p_wdata;
    logic [DATA_W/8-1:0]          p_strb;
    logic [2:0]                   p_prot;
    logic [NUM_SLAVES-1:0]        p_ready;
    logic [NUM_SLAVES*DATA_W-1:0] p_rdata;
    logic [NUM_SLAVES-1:0]        p_slverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot, rsp_ready,
               p_clk_en, p_ready, p_rdata, p_slverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
               p_sel, p_enable, p_addr, p_write, p_wdata, p_strb, p_prot
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot, rsp_ready,
               p_clk_en, p_ready, p_rdata, p_slverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
               p_sel, p_enable, p_addr, p_write, p_wdata, p_strb, p_prot
    );
endinterface

// File: rtl/apb_timeout_counter.sv
// apb_timeout_counter: counts stalled PCLK ticks and flags the tick that exhausts the budget
module apb_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    input  logic stall,
    output logic expired
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] count;

    always_comb expired = (TIMEOUT > 0) && tick && stall && count == CW'(TIMEOUT - 1);

    always_ff @(posedge clk)
        if (reset || clear) count <= '0;
        else if (tick && stall && !expired) count <= count + 1'b1;
endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-outstanding request-to-APB bridge with address decode and wait-state timeout
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SLV_AW     = 12,
    parameter int TIMEOUT    = 16
) (
    input logic                clk,
    input logic                reset,
    apb_master_ctrl_if.master  bus
);
    localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;

    state_t            state, state_nx;
    logic [IW-1:0]     idx, dec_idx;
    logic              mapped, sel_ready, sel_slverr, expired;
    logic [DATA_W-1:0] sel_rdata;

    // index and upper bits together must form a number below NUM_SLAVES
    always_comb begin
        mapped     = (bus.req_addr >> SLV_AW) < ADDR_W'(NUM_SLAVES);
        dec_idx    = IW'(bus.req_addr >> SLV_AW);
        sel_ready  = bus.p_ready[idx];
        sel_slverr = bus.p_slverr[idx];
        sel_rdata  = bus.p_rdata[idx*DATA_W +: DATA_W];
    end

    apb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != DATA),
        .tick    (bus.p_clk_en && state == DATA),
        .stall   (!sel_ready),
        .expired (expired)
    );

    always_ff @(posedge clk) state <= reset ? IDLE : state_nx;

    always_comb
        state_nx = state == IDLE    ? (bus.req_valid ? (mapped ? ADDRESS : RESP) : IDLE) :
                   state == ADDRESS ? (bus.p_clk_en ? DATA : ADDRESS) :
                   state == DATA    ? ((bus.p_clk_en && sel_ready) || expired ? RESP : DATA) :
                                      (bus.rsp_ready ? IDLE : RESP);

    always_comb begin
        bus.req_ready = state == IDLE;
        bus.rsp_valid = state == RESP;
        bus.p_enable  = state == DATA;
        bus.p_sel     = (state == ADDRESS || state == DATA) ? NUM_SLAVES'(1) << idx : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx             <= '0;
            bus.p_addr      <= '0;
            bus.p_write     <= 1'b0;
            bus.p_wdata     <= '0;
            bus.p_strb      <= '0;
            bus.p_prot      <= '0;
            bus.rsp_rdata   <= '0;
            bus.rsp_resp    <= RESP_OKAY;
            bus.rsp_timeout <= 1'b0;
        end else if (state == IDLE && bus.req_valid) begin
            idx             <= dec_idx;
            bus.p_addr      <= bus.req_addr;
            bus.p_write     <= bus.req_write;
            bus.p_wdata     <= bus.req_wdata;
            bus.p_strb      <= bus.req_write ? bus.req_strb : '0;
            bus.p_prot      <= bus.req_prot;
            bus.rsp_rdata   <= '0;
            bus.rsp_resp    <= mapped ? RESP_OKAY : RESP_DECERR;
            bus.rsp_timeout <= 1'b0;
        end else if (state == DATA && bus.p_clk_en && sel_ready) begin
            bus.rsp_rdata   <= bus.p_write ? '0 : sel_rdata;
            bus.rsp_resp    <= sel_slverr ? RESP_SLVERR : RESP_OKAY;
            bus.rsp_timeout <= 1'b0;
        end else if (expired) begin
            bus.rsp_rdata   <= '0;
            bus.rsp_resp    <= RESP_SLVERR;
            bus.rsp_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: scoreboard bench with a wait-state responder and a transfer-level reference model
module tb_apb_master_ctrl;
    localparam int NS = 4, AW = 32, DW = 32, SAW = 12, TO = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    apb_master_ctrl_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_ctrl #(
        .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SLV_AW(SAW), .TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t q[$];
    exp_t mon_e;
    int total = 0, bad = 0, done = 0;
    int addr_tot = 0, data_tot = 0, tick_tot = 0, sel_tot = 0;
    logic [31:0] cur_addr = 0, cur_wdata = 0, cur_rdata = 0;
    logic [3:0]  cur_strb = 0;
    logic [2:0]  cur_prot = 0;
    logic        cur_write = 0, cur_slverr = 0, cur_dec = 0;
    int          cur_idx = 0, cur_wait = 0;
    int          en_mode = 0, ticks_seen = 0;
    logic        en_tog = 1'b0, hold = 1'b0;
    logic        prev_en = 1'b0, prev_rst = 1'b1, prev_pen = 1'b0;
    logic [NS-1:0] prev_sel = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transfer outcome from address map, wait budget and slave behaviour alone
    function automatic exp_t model(input logic [31:0] a, input logic w, input int wt,
                                   input logic se, input logic [31:0] rd);
        exp_t e;
        if ((a >> SAW) >= NS) e = {32'd0, 2'd3, 1'b0};
        else if (TO > 0 && wt >= TO) e = {32'd0, 2'd2, 1'b1};
        else e = {w ? 32'd0 : rd, se ? 2'd2 : 2'd0, 1'b0};
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        bus.p_clk_en = en_mode == 0 ? 1'b1 : en_mode == 1 ? en_tog : 1'($urandom_range(0, 2) != 0);
        en_tog = ~en_tog;
        bus.p_ready = NS'($urandom);
        bus.p_slverr = NS'($urandom);
        for (int i = 0; i < NS; i++) bus.p_rdata[i*DW +: DW] = $urandom;
        if (!bus.p_enable) ticks_seen = 0;
        else if (bus.p_clk_en) begin
            bus.p_ready[cur_idx] = ticks_seen >= cur_wait;
            bus.p_slverr[cur_idx] = cur_slverr;
            bus.p_rdata[cur_idx*DW +: DW] = cur_rdata;
            if (ticks_seen < cur_wait) ticks_seen++;
        end
    end

    always @(posedge clk) begin
        #1;
        bus.rsp_ready = hold ? 1'b0 : 1'($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got resp %0h expected none", bus.rsp_resp);
            end else begin
                mon_e = q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                chk("rsp_resp", 32'(bus.rsp_resp), 32'(mon_e.resp));
                chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(mon_e.to));
            end
            done++;
        end
        if (bus.p_sel != 0) begin
            sel_tot++;
            chk("p_sel", 32'(bus.p_sel), cur_dec ? 32'd0 : 32'(1) << cur_idx);
            chk("p_addr", bus.p_addr, cur_addr);
            chk("p_write", 32'(bus.p_write), 32'(cur_write));
            chk("p_wdata", bus.p_wdata, cur_wdata);
            chk("p_strb", 32'(bus.p_strb), cur_write ? 32'(cur_strb) : 32'd0);
            chk("p_prot", 32'(bus.p_prot), 32'(cur_prot));
        end
        if (bus.p_enable) begin
            data_tot++;
            chk("p_enable_sel", 32'(bus.p_sel != 0), 32'd1);
        end else if (bus.p_sel != 0) addr_tot++;
        if (bus.p_enable && bus.p_clk_en) tick_tot++;
        if (prev_sel != 0 && !prev_rst && (bus.p_sel != prev_sel || bus.p_enable != prev_pen))
            chk("apb_move_on_en", 32'(prev_en), 32'd1);
        prev_sel = bus.p_sel;
        prev_pen = bus.p_enable;
        prev_en  = bus.p_clk_en;
        prev_rst = reset;
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] st,
                         input logic [2:0] pr, input int wt, input logic se, input logic [31:0] rd);
        cur_addr = a; cur_write = w; cur_wdata = wd; cur_strb = st; cur_prot = pr;
        cur_wait = wt; cur_slverr = se; cur_rdata = rd;
        cur_idx = int'((a >> SAW) & 32'd3);
        cur_dec = (a >> SAW) >= NS;
        q.push_back(model(a, w, wt, se, rd));
        bus.req_addr = a; bus.req_write = w; bus.req_wdata = wd; bus.req_strb = st; bus.req_prot = pr;
        bus.req_valid = 1'b1;
        for (int t = 0; !bus.req_ready; t++) begin
            if (t == 100) begin
                chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_write = 1'($urandom);
        bus.req_strb = 4'($urandom); bus.req_prot = 3'($urandom);
    endtask

    task automatic wait_done(input int target);
        for (int t = 0; done < target; t++) begin
            if (t == 400) begin
                chk("rsp_wait", 32'(done), 32'(target));
                q.delete();
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_req(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] st,
                           input logic [2:0] pr, input int wt, input logic se, input logic [31:0] rd);
        int d0;
        d0 = done;
        issue(a, w, wd, st, pr, wt, se, rd);
        wait_done(d0 + 1);
    endtask

    initial begin
        int a0, dt0, t0, s0, d0;
        logic [31:0] a;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_wdata = '0;
        bus.req_strb = '0; bus.req_prot = '0; bus.rsp_ready = 1'b0; bus.p_clk_en = 1'b0;
        bus.p_ready = '0; bus.p_slverr = '0; bus.p_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_resp", 32'(bus.rsp_resp), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        chk("rst_p_sel", 32'(bus.p_sel), 32'd0);
        chk("rst_p_enable", 32'(bus.p_enable), 32'd0);
        chk("rst_p_addr", bus.p_addr, 32'd0);
        chk("rst_p_wdata", bus.p_wdata, 32'd0);
        chk("rst_p_strb_prot_write", {bus.p_strb, bus.p_prot, bus.p_write}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        en_mode = 0;
        a0 = addr_tot; dt0 = data_tot;
        run_req(32'h1000, 1'b1, 32'hA5A5_A5A5, 4'hF, 3'd2, 0, 1'b0, 32'h0);
        chk("wr_addr_cycles", 32'(addr_tot - a0), 32'd1);
        chk("wr_data_cycles", 32'(data_tot - dt0), 32'd1);

        en_mode = 1;
        t0 = tick_tot;
        run_req(32'h2004, 1'b0, 32'h0, 4'hF, 3'd0, 3, 1'b0, 32'hDEAD_BEEF);
        chk("rd_wait_ticks", 32'(tick_tot - t0), 32'd4);

        en_mode = 0;
        s0 = sel_tot; d0 = done;
        issue(32'h5000, 1'b0, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h0);
        chk("decerr_next_cycle", 32'(bus.rsp_valid), 32'd1);
        wait_done(d0 + 1);
        chk("decerr_no_psel", 32'(sel_tot - s0), 32'd0);

        t0 = tick_tot;
        run_req(32'h0010, 1'b0, 32'h0, 4'h0, 3'd1, 1000, 1'b0, 32'h1234_5678);
        chk("timeout_ticks", 32'(tick_tot - t0), 32'd4);
        t0 = tick_tot;
        run_req(32'h0020, 1'b0, 32'h0, 4'h0, 3'd1, 3, 1'b0, 32'h8765_4321);
        chk("ready_on_last_tick", 32'(tick_tot - t0), 32'd4);

        hold = 1'b1;
        d0 = done;
        issue(32'h3008, 1'b1, 32'h0BAD_F00D, 4'h3, 3'd7, 0, 1'b1, 32'h0);
        for (int t = 0; !bus.rsp_valid && t < 50; t++) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_rsp_resp", 32'(bus.rsp_resp), 32'd2);
            chk("hold_rsp_rdata", bus.rsp_rdata, 32'd0);
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        hold = 1'b0;
        wait_done(d0 + 1);

        issue(32'h1040, 1'b1, 32'h5555_AAAA, 4'hC, 3'd0, 2, 1'b0, 32'h0);
        for (int t = 0; !bus.p_enable && t < 50; t++) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        void'(q.pop_back());
        chk("midrst_p_sel", 32'(bus.p_sel), 32'd0);
        chk("midrst_p_enable", 32'(bus.p_enable), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_p_addr", bus.p_addr, 32'd0);
        run_req(32'h2100, 1'b0, 32'h0, 4'h0, 3'd0, 1, 1'b0, 32'hCAFE_0001);

        for (int n = 0; n < 40; n++) begin
            en_mode = $urandom_range(0, 2);
            a = (32'($urandom_range(0, 7)) << SAW) | ($urandom & 32'hFFC);
            if ($urandom_range(0, 9) == 0) a = a | 32'h0010_0000;
            run_req(a, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                    $urandom_range(0, 5), 1'($urandom), $urandom);
        end

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
